// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported, fixed-latency unified memory between the
//   instruction-fetch (IF) and data-memory (MEM) stages of a 5-stage RISC-V
//   pipeline. The arbiter grants one access at a time and round-robins under
//   contention. It times each access with a down-counter and returns read
//   data through one-cycle ready pulses. It also drives the pipeline stall
//   signals.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   memory data width (one doubleword, at least 64)
//   MEM_LAT  memory access latency in cycles, legal range 1..15
//
// Ports
//   clk, reset                    clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush       fetch request, byte address, branch flush
//   if_ready/if_rdata             fetch completion pulse, 32-bit instruction
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_funct3            data request, store flag, address, data, size
//   dm_ready/dm_rdata             data completion pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_funct3          registered memory command, stable per access
//   mem_rdata                     memory read data, valid when cnt reaches 0
//   stall_if, stall_mem           combinational pipeline freeze requests
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [31:0]       if_rdata,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

  localparam int unsigned   CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [2:0]    FUNCT3_W = 3'b010;  // 32-bit instruction word

  state_t            state;
  grant_t            last_grant;
  logic [CNT_W-1:0]  cnt;
  logic              cancel;

  logic              if_elig;
  logic              dm_elig;
  logic              pick_dm;
  logic              pick_if;
  logic              fetch_drop;
  logic [31:0]       fetch_word;

  // A port that is in its own ready cycle has just been served and must
  // not be granted again.
  always_comb begin
    if_elig = if_req & ~if_ready;
    dm_elig = dm_req & ~dm_ready;
    pick_dm = dm_elig & (~if_elig | (last_grant == GRANT_IF));
    pick_if = if_elig & ~pick_dm;
  end

  // A flush that arrives on the completion edge itself also discards the
  // fetch, because the instruction is stale either way.
  always_comb begin
    fetch_drop = cancel | if_flush;
    fetch_word = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  end

  always_comb begin
    stall_if  = if_req & ~if_ready;
    stall_mem = dm_req & ~dm_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      cnt        <= '0;
      cancel     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_dm) begin
            state      <= DATA;
            mem_en     <= 1'b1;
            mem_we     <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            mem_funct3 <= dm_funct3;
            cnt        <= CNT_INIT;
            last_grant <= GRANT_DM;
          end else if (pick_if) begin
            state      <= FETCH;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_funct3 <= FUNCT3_W;
            cnt        <= CNT_INIT;
            last_grant <= GRANT_IF;
          end
        end

        FETCH: begin
          if (if_flush) begin
            cancel <= 1'b1;
          end
          if (cnt == '0) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            cancel <= 1'b0;
            if (!fetch_drop) begin
              if_ready <= 1'b1;
              if_rdata <= fetch_word;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            state    <= IDLE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            dm_ready <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MEM_LAT = 2;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [2:0]        dm_funct3;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  int unsigned checks;
  int unsigned errors;

  unified_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_funct3 (dm_funct3),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_funct3(mem_funct3),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;
    mem_rdata = '0;
    #12;
    checks++;
    if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got en/we/ifr/dmr=%b required 0000", {mem_en, mem_we, if_ready, dm_ready});
    end
    checks++;
    if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_funct3 !== 3'b000) begin
      errors++;
      $display("FAIL reset_mem: got addr=%h wdata=%h f3=%b required zeros", mem_addr, mem_wdata, mem_funct3);
    end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got if=%h dm=%h required 0", if_rdata, dm_rdata);
    end
    checks++;
    if ({stall_if, stall_mem} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall: got %b required 00", {stall_if, stall_mem});
    end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1;
    if_addr = 64'h4;
    mem_rdata = 64'h11111111_00A00093;
    #1;
    checks++;
    if (stall_if !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_c1: got %b required 1", stall_if);
    end
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h4 || mem_funct3 !== 3'b010) begin
      errors++;
      $display("FAIL fetch_grant: got en=%b we=%b addr=%h f3=%b required 1 0 4 010", mem_en, mem_we, mem_addr, mem_funct3);
    end
    checks++;
    if (stall_if !== 1'b1 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c2: got stall=%b ready=%b required 1 0", stall_if, if_ready);
    end
    tick();
    checks++;
    if (stall_if !== 1'b1 || if_ready !== 1'b0 || mem_en !== 1'b1) begin
      errors++;
      $display("FAIL fetch_c3: got stall=%b ready=%b en=%b required 1 0 1", stall_if, if_ready, mem_en);
    end
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL fetch_done: got ready=%b rdata=%h required 1 11111111", if_ready, if_rdata);
    end
    checks++;
    if (stall_if !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_release: got stall=%b en=%b required 0 0", stall_if, mem_en);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if (if_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse_end: got ready=%b en=%b required 0 0", if_ready, mem_en);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    if_req = 1'b1; if_addr = 64'h8;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100; dm_funct3 = 3'b011;
    mem_rdata = 64'hCAFEBABE_12345678;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h100 || mem_funct3 !== 3'b011) begin
      errors++;
      $display("FAIL cont_data_first: got en=%b we=%b addr=%h f3=%b required 1 0 100 011", mem_en, mem_we, mem_addr, mem_funct3);
    end
    tick();
    tick();
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 64'hCAFEBABE_12345678) begin
      errors++;
      $display("FAIL cont_load: got ready=%b rdata=%h required 1 cafebabe12345678", dm_ready, dm_rdata);
    end
    checks++;
    if (stall_if !== 1'b1 || stall_mem !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL cont_idle: got stall_if=%b stall_mem=%b en=%b required 1 0 0", stall_if, stall_mem, mem_en);
    end
    dm_req = 1'b0;
    mem_rdata = 64'h87654321_0000A0B3;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h8 || dm_ready !== 1'b0 || stall_if !== 1'b1) begin
      errors++;
      $display("FAIL cont_fetch_grant: got en=%b addr=%h dmr=%b stall=%b required 1 8 0 1", mem_en, mem_addr, dm_ready, stall_if);
    end
    tick();
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h0000A0B3) begin
      errors++;
      $display("FAIL cont_fetch_done: got ready=%b rdata=%h required 1 0000a0b3", if_ready, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'hDEAD; dm_funct3 = 3'b011;
    mem_rdata = 64'h55555555_55555555;
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      tick();
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h40 || mem_wdata !== 64'hDEAD || mem_funct3 !== 3'b011) begin
        errors++;
        $display("FAIL store_cmd[%0d]: got en=%b we=%b addr=%h wdata=%h f3=%b required 1 1 40 dead 011", i, mem_en, mem_we, mem_addr, mem_wdata, mem_funct3);
      end
    end
    tick();
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 64'hCAFEBABE_12345678 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL store_done: got ready=%b rdata=%h we=%b required 1 cafebabe12345678 0", dm_ready, dm_rdata, mem_we);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    checks++;
    if (dm_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_pulse_end: got %b required 0", dm_ready);
    end
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 64'h10;
    mem_rdata = 64'h99999999_77777777;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h10) begin
      errors++;
      $display("FAIL flush_grant: got en=%b addr=%h required 1 10", mem_en, mem_addr);
    end
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    if_req = 1'b0;
    if_addr = 64'h80;
    tick();
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h0000A0B3 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_cancel: got ready=%b rdata=%h en=%b required 0 0000a0b3 0", if_ready, if_rdata, mem_en);
    end
    if_req = 1'b1;
    mem_rdata = 64'h13579BDF_02468ACE;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h80) begin
      errors++;
      $display("FAIL flush_reissue: got en=%b addr=%h required 1 80", mem_en, mem_addr);
    end
    tick();
    tick();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h02468ACE) begin
      errors++;
      $display("FAIL flush_refetch: got ready=%b rdata=%h required 1 02468ace", if_ready, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    logic [ADDR_W-1:0] exp_addr;
    if_req = 1'b1; if_addr = 64'h4C;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200; dm_funct3 = 3'b011;
    mem_rdata = 64'hA5A5A5A5_5A5A5A5A;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 64'h200 : 64'h4C;
      tick();
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got en=%b addr=%h required 1 %h", i, mem_en, mem_addr, exp_addr);
      end
      tick();
      tick();
      checks++;
      if ({dm_ready, if_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fair_ready[%0d]: got dm/if=%b required %b", i, {dm_ready, if_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_data();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h300; dm_funct3 = 3'b011;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h300) begin
      errors++;
      $display("FAIL rst_mid_grant: got en=%b addr=%h required 1 300", mem_en, mem_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || dm_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got en=%b ready=%b required 0 0", mem_en, dm_ready);
    end
    dm_req = 1'b0;
    tick();
    #3 reset = 1'b1;
    tick();
    checks++;
    if (dm_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_nopulse: got ready=%b en=%b required 0 0", dm_ready, mem_en);
    end
    if_req = 1'b1; if_addr = 64'h20;
    dm_req = 1'b1; dm_addr = 64'h308;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h308 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_regrant: got en=%b addr=%h we=%b required 1 308 0", mem_en, mem_addr, mem_we);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_flush();
    test_fairness();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, multi-cycle unified memory between the instruction-fetch stage (IF) and the data-memory stage (MEM) of the 5-stage RISC-V pipeline.
- Sits between the IF/MEM stages and the memory. Grants one access at a time and times each access with a fixed-latency counter.
- Returns read data to the requester through a one-cycle ready pulse. Drives the stall signals the pipeline uses to freeze PC, IF_ID and EX_MEM.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width (one doubleword).
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request (level).
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  taken branch resolved in MEM; cancels the in-flight fetch.
- if_ready  out  1  fetch complete pulse.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  data request (MemRead|MemWrite, level).
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_funct3  in  3  access size/sign.
- dm_ready  out  1  data access complete pulse.
- dm_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_funct3  out  3  memory access size.
- mem_rdata  in  DATA_W  memory read data, valid when the counter reaches 0.
- stall_if  out  1  freeze PC/IF_ID.
- stall_mem  out  1  freeze EX_MEM and upstream.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, last_grant=IF, cancel=0.
  - All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, mem_funct3, if_ready, dm_ready, if_rdata, dm_rdata.
  - Reset asserted mid-access aborts the access immediately; mem_en drops asynchronously and no ready pulse is produced.
- States: IDLE, FETCH, DATA.
- IDLE, per clock edge:
  - Eligible requests: if_req & ~if_ready and dm_req & ~dm_ready. A port is not eligible in its own ready cycle.
  - Only DATA eligible -> go to DATA. Only FETCH eligible -> go to FETCH.
  - Both eligible -> grant the port not in last_grant (round-robin). First contention after reset goes to DATA.
  - On grant: latch addr/we/wdata/funct3 into the mem_* registers, set mem_en=1, cnt=MEM_LAT-1, last_grant=granted port.
  - For a fetch grant, mem_we=0 and mem_funct3=3'b010.
- FETCH/DATA: mem_* outputs are held stable for the whole access. cnt decrements each cycle.
- Completion (edge where cnt==0 in FETCH or DATA):
  - Capture mem_rdata. State -> IDLE, mem_en=0, mem_we=0.
  - Pulse the ready of the granted port for exactly one cycle.
  - FETCH: if_rdata = mem_rdata[31:0] when latched addr[2]=0, else mem_rdata[63:32]. If_ready is not pulsed and if_rdata is not updated when cancel=1.
  - DATA load: dm_rdata = mem_rdata. DATA store: dm_rdata holds its previous value.
- Latency: the request is sampled in IDLE at edge t. The ready pulse is high in the cycle following edge t+MEM_LAT.
- Back-to-back: the ready cycle is an IDLE cycle. Any other eligible request is granted at the next edge, so there is one idle cycle between accesses.
- Flush:
  - if_flush=1 while in FETCH sets cancel=1. The access still runs to completion because the memory is not abortable.
  - cancel clears at completion.
  - if_flush in IDLE or DATA has no effect.
- Stalls (combinational):
  - stall_if = if_req & ~if_ready.
  - stall_mem = dm_req & ~dm_ready.
  - Both may be high simultaneously.
- dm_req/if_req dropped while their access is in flight: the access completes and the ready pulse still occurs; the requester ignores it.

Test Plan:
- Reset then a single fetch (MEM_LAT=2): if_req=1, if_addr=0x4, mem_rdata=0x11111111_00A00093 -> if_ready pulses 3 cycles after the request edge; if_rdata=0x11111111; stall_if high for 3 cycles.
- Contention: if_req=1 and dm_req=1 (load, addr 0x100) in the same cycle after reset -> DATA granted first (mem_addr=0x100, mem_we=0). FETCH is granted one idle cycle after dm_ready; stall_if stays high throughout.
- Store: dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD, funct3=3'b011 -> mem_we=1 with stable mem_* for MEM_LAT cycles; dm_ready pulses; dm_rdata is unchanged.
- Flush: if_flush=1 one cycle into FETCH -> no if_ready pulse and if_rdata is unchanged. State returns to IDLE after MEM_LAT; a re-issued if_req to 0x80 is then serviced normally.
- Fairness: if_req and dm_req held high continuously -> grants alternate DATA, FETCH, DATA, FETCH. No port waits for more than one other access.
- Reset mid-DATA: reset=0 while cnt=1 -> mem_en=0 immediately; no dm_ready pulse; after release, state=IDLE and the first contention grants DATA.
